wb_stage: RTL and testbench
===========================

# wb_stage

Writeback stage of the MIPS pipeline: accepts one retiring instruction at a time from the MEM stage. For loads it waits for the data-memory response and sign/zero-extends the selected byte or halfword. It then drives a single-cycle write (WB, writeReg, writeData) into RegisterFile, which is the producer side of the register file's write port. A flush input discards a pending instruction, including a late memory response.

## Interface
Parameters:
- DATA_W, 32, datapath width; only 32 is supported.
- REG_AW, 5, register address width.

Ports:
- clk  in  1  pipeline clock; all state updates on rising edge.
- rst  in  1  reset, synchronous, active-high.
- in_valid  in  1  MEM stage presents an instruction.
- in_ready  out  1  stage can accept this cycle; transfer occurs when in_valid && in_ready.
- in_regWrite  in  1  instruction writes a register.
- in_memToReg  in  1  result comes from data memory (load).
- in_loadType  in  3  0 LW, 1 LH, 2 LHU, 3 LB, 4 LBU; 5-7 treated as LW.
- in_writeReg  in  REG_AW  destination register.
- in_aluResult  in  DATA_W  ALU result; bits [1:0] give the load byte offset.
- mem_rdata  in  DATA_W  data-memory read word.
- mem_rdataValid  in  1  mem_rdata valid this cycle; one pulse per issued load.
- flush  in  1  discard any in-flight instruction.
- WB  out  1  register-file write enable, one-cycle pulse.
- writeReg  out  REG_AW  write address, valid while WB is high.
- writeData  out  DATA_W  write data, valid while WB is high.
- misalign  out  1  one-cycle pulse: load offset illegal for its width.

## Operation
- FSM states: IDLE, WAIT_MEM, WRITE, DRAIN.
- IDLE: in_ready=1. On accept, capture the instruction fields.
  - memToReg=1: go to WAIT_MEM.
  - otherwise: go to WRITE with data = in_aluResult.
- WAIT_MEM: in_ready=0. On mem_rdataValid, extend the data per loadType and go to WRITE.
- WRITE: WB = regWrite && (writeReg != 0).
  - in_ready=1, so a new instruction may be accepted in the same cycle (back-to-back).
  - Next state follows the IDLE rules if an instruction was accepted, else IDLE.
- DRAIN: in_ready=0. Entered by a flush in WAIT_MEM. Waits for mem_rdataValid, discards the data, then goes to IDLE.
- Load extension is big-endian. Byte k (k = aluResult[1:0]) = mem_rdata[31-8k : 24-8k]. Half h (h = aluResult[1]) = mem_rdata[31-16h : 16-16h].
  - LB/LH: sign-extend. LBU/LHU: zero-extend. LW: whole word.
- Misalignment:
  - LW with offset != 0, or LH/LHU with offset[0] = 1: pulse misalign in the WRITE cycle.
  - The write still occurs with LW using the raw word and LH/LHU using half h.
- Flush priority by state:
  - IDLE: blocks acceptance that cycle.
  - WAIT_MEM: go to DRAIN, or to IDLE if mem_rdataValid is also high that cycle.
  - WRITE: suppresses WB and blocks acceptance; go to IDLE.
  - DRAIN: no effect.
- mem_rdataValid in IDLE or WRITE is ignored; the protocol forbids it.
- A register-0 destination never produces WB. The pipeline still advances.

## Timing
- Reset values: state=IDLE, WB=0, writeReg=0, writeData=0, misalign=0.
- in_ready=0 while rst is high and 1 in the first cycle after reset.
- ALU instruction accepted at edge N: WB high for cycle N..N+1 (1-cycle latency).
- Load accepted at N, mem_rdataValid first seen at edge M (M >= N+1): WB in cycle M..M+1.
- WB is registered; writeReg and writeData are stable whenever WB is high.
- Throughput is one ALU instruction per cycle. Loads cost 1 + memory latency.
- Reset mid-operation: immediate return to IDLE. Outstanding memory responses are not tracked.

## Structure
- Shared package `mips_pkg`:
  - loadType encodings LT_LW..LT_LBU.
  - DATA_W and REG_AW constants.
  - FSM state typedef.
- Sub-module `load_extend`: combinational. Inputs loadType, offset, rdata. Outputs the extended word and misalign. Reusable by the MEM-stage forwarding path.

## Test plan
- ALU write: accept regWrite=1, writeReg=20, aluResult=50 at edge N -> WB=1, writeReg=20, writeData=50 in cycle N+1 only.
- Load extension:
  - mem_rdata=0x80F17F01, LB, offset 0 -> writeData 0xFFFFFF80.
  - LBU offset 1 -> 0x000000F1.
  - LH offset 2 -> 0x00007F01.
  - LHU offset 0 -> 0x000080F1.
- Memory wait: load accepted, mem_rdataValid 3 cycles later -> in_ready=0 for 3 cycles, WB exactly one cycle after the valid.
- Flush in WAIT_MEM, response 2 cycles later -> no WB, in_ready returns 1 the cycle after the response. A following ALU op writes normally.
- Register 0 and misalignment:
  - writeReg=0, regWrite=1 -> WB never asserted.
  - LW at offset 2 -> misalign pulse and WB with the raw word.
- Back-to-back and reset:
  - Four consecutive ALU ops -> four consecutive WB cycles.
  - rst asserted while in WAIT_MEM -> next cycle WB=0, writeData=0, in_ready=0 during rst and 1 after.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared MIPS pipeline definitions: datapath constants, load-type encodings
// and the writeback-stage FSM state type.
package mips_pkg;

    localparam int DATA_W = 32;
    localparam int REG_AW = 5;

    localparam logic [2:0] LT_LW  = 3'd0;
    localparam logic [2:0] LT_LH  = 3'd1;
    localparam logic [2:0] LT_LHU = 3'd2;
    localparam logic [2:0] LT_LB  = 3'd3;
    localparam logic [2:0] LT_LBU = 3'd4;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_WAIT_MEM = 2'd1,
        ST_WRITE    = 2'd2,
        ST_DRAIN    = 2'd3
    } wb_state_t;

    // Unused encodings 5-7 behave as a full-word load.
    function automatic logic is_word_load(input logic [2:0] load_type);
        is_word_load = (load_type == LT_LW) || (load_type > LT_LBU);
    endfunction

endpackage

// File: rtl/load_extend.sv
// Big-endian byte/halfword selection and sign/zero extension of a loaded word,
// plus detection of offsets that are illegal for the access width.
module load_extend
    import mips_pkg::*;
(
    input  logic [2:0]  i_load_type,
    input  logic [1:0]  i_offset,
    input  logic [31:0] i_rdata,
    output logic [31:0] o_data,
    output logic        o_misalign
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    // Byte 0 is the most significant byte of the word.
    always_comb begin
        case (i_offset)
            2'd0:    w_byte = i_rdata[31:24];
            2'd1:    w_byte = i_rdata[23:16];
            2'd2:    w_byte = i_rdata[15:8];
            2'd3:    w_byte = i_rdata[7:0];
            default: w_byte = i_rdata[31:24];
        endcase
        if (i_offset[1]) begin
            w_half = i_rdata[15:0];
        end else begin
            w_half = i_rdata[31:16];
        end
    end

    // Extension and misalignment per access width.
    always_comb begin
        o_data     = i_rdata;
        o_misalign = 1'b0;
        case (i_load_type)
            LT_LH: begin
                o_data     = {{16{w_half[15]}}, w_half};
                o_misalign = i_offset[0];
            end
            LT_LHU: begin
                o_data     = {16'h0000, w_half};
                o_misalign = i_offset[0];
            end
            LT_LB:   o_data = {{24{w_byte[7]}}, w_byte};
            LT_LBU:  o_data = {24'h000000, w_byte};
            default: begin
                o_data     = i_rdata;
                o_misalign = is_word_load(i_load_type) && (i_offset != 2'd0);
            end
        endcase
    end

endmodule

// File: rtl/wb_stage.sv
// MIPS writeback stage: accepts one retiring instruction, waits for load data
// when needed, and issues a single-cycle register-file write.
module wb_stage
    import mips_pkg::*;
#(
    parameter int DATA_W = mips_pkg::DATA_W,
    parameter int REG_AW = mips_pkg::REG_AW
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_regWrite,
    input  logic              in_memToReg,
    input  logic [2:0]        in_loadType,
    input  logic [REG_AW-1:0] in_writeReg,
    input  logic [DATA_W-1:0] in_aluResult,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_rdataValid,
    input  logic              flush,
    output logic              WB,
    output logic [REG_AW-1:0] writeReg,
    output logic [DATA_W-1:0] writeData,
    output logic              misalign
);

    wb_state_t         r_state;
    logic              r_wb;
    logic              r_misalign;
    logic [REG_AW-1:0] r_write_reg;
    logic [DATA_W-1:0] r_write_data;
    logic              r_wr_en;
    logic [2:0]        r_load_type;
    logic [1:0]        r_offset;

    logic              w_accept;
    logic              w_alu_wr_en;
    logic [31:0]       w_ext_data;
    logic              w_ext_misalign;

    load_extend u_load_extend (
        .i_load_type (r_load_type),
        .i_offset    (r_offset),
        .i_rdata     (mem_rdata),
        .o_data      (w_ext_data),
        .o_misalign  (w_ext_misalign)
    );

    assign in_ready    = !rst && ((r_state == ST_IDLE) || (r_state == ST_WRITE));
    assign w_accept    = in_valid && in_ready && !flush;
    assign w_alu_wr_en = in_regWrite && (in_writeReg != {REG_AW{1'b0}});

    // r_wb is only ever high in WRITE, so a flush there cancels the write.
    assign WB        = r_wb && !flush;
    assign misalign  = r_misalign && !flush;
    assign writeReg  = r_write_reg;
    assign writeData = r_write_data;

    // Writeback FSM with registered write strobe, address and data.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_wb         <= 1'b0;
            r_misalign   <= 1'b0;
            r_write_reg  <= {REG_AW{1'b0}};
            r_write_data <= {DATA_W{1'b0}};
            r_wr_en      <= 1'b0;
            r_load_type  <= LT_LW;
            r_offset     <= 2'd0;
        end else begin
            r_wb       <= 1'b0;
            r_misalign <= 1'b0;
            case (r_state)
                ST_IDLE, ST_WRITE: begin
                    if (w_accept) begin
                        r_write_reg <= in_writeReg;
                        r_wr_en     <= w_alu_wr_en;
                        r_load_type <= in_loadType;
                        r_offset    <= in_aluResult[1:0];
                        if (in_memToReg) begin
                            r_state <= ST_WAIT_MEM;
                        end else begin
                            r_state      <= ST_WRITE;
                            r_wb         <= w_alu_wr_en;
                            r_write_data <= in_aluResult;
                        end
                    end else begin
                        r_state <= ST_IDLE;
                    end
                end
                ST_WAIT_MEM: begin
                    if (flush) begin
                        r_state <= mem_rdataValid ? ST_IDLE : ST_DRAIN;
                    end else if (mem_rdataValid) begin
                        r_state      <= ST_WRITE;
                        r_wb         <= r_wr_en;
                        r_write_data <= w_ext_data;
                        r_misalign   <= w_ext_misalign;
                    end else begin
                        r_state <= ST_WAIT_MEM;
                    end
                end
                ST_DRAIN: begin
                    if (mem_rdataValid) begin
                        r_state <= ST_IDLE;
                    end else begin
                        r_state <= ST_DRAIN;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_wb_stage.sv
// Self-checking bench for wb_stage: directed timing checks per scenario plus a
// scoreboard of expected register-file writes consumed by a WB monitor.
module tb_wb_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic        in_regWrite;
    logic        in_memToReg;
    logic [2:0]  in_loadType;
    logic [4:0]  in_writeReg;
    logic [31:0] in_aluResult;
    logic [31:0] mem_rdata;
    logic        mem_rdataValid;
    logic        flush;
    logic        WB;
    logic [4:0]  writeReg;
    logic [31:0] writeData;
    logic        misalign;

    typedef struct {
        logic [4:0]  r;
        logic [31:0] d;
        logic        m;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    wb_stage dut (
        .clk            (clk),
        .rst            (rst),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .in_regWrite    (in_regWrite),
        .in_memToReg    (in_memToReg),
        .in_loadType    (in_loadType),
        .in_writeReg    (in_writeReg),
        .in_aluResult   (in_aluResult),
        .mem_rdata      (mem_rdata),
        .mem_rdataValid (mem_rdataValid),
        .flush          (flush),
        .WB             (WB),
        .writeReg       (writeReg),
        .writeData      (writeData),
        .misalign       (misalign)
    );

    always #5 clk = ~clk;

    // Scoreboard: every WB must match the oldest expected write.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (WB) begin
                    checks++;
                    if (exp_q.size() == 0) begin
                        errors++;
                        $display("FAIL unexpected_wb got reg=%0d data=%h expected no write", writeReg, writeData);
                    end else begin
                        e = exp_q.pop_front();
                        if ({writeReg, writeData, misalign} !== {e.r, e.d, e.m}) begin
                            errors++;
                            $display("FAIL wb_content got reg=%0d data=%h mis=%b expected reg=%0d data=%h mis=%b",
                                     writeReg, writeData, misalign, e.r, e.d, e.m);
                        end
                    end
                end else if (misalign) begin
                    checks++;
                    errors++;
                    $display("FAIL misalign_without_wb got misalign=1 expected 0");
                end
            end
        end
    end

    function automatic logic [31:0] model_ext(input logic [2:0] lt, input logic [1:0] off, input logic [31:0] w);
        logic [7:0]  b;
        logic [15:0] h;
        b = 8'(w >> (24 - 8 * int'(off)));
        h = 16'(w >> (16 - 16 * int'(off[1])));
        case (lt)
            3'd1:    return {{16{h[15]}}, h};
            3'd2:    return {16'h0000, h};
            3'd3:    return {{24{b[7]}}, b};
            3'd4:    return {24'h000000, b};
            default: return w;
        endcase
    endfunction

    function automatic logic model_mis(input logic [2:0] lt, input logic [1:0] off);
        if (lt == 3'd1 || lt == 3'd2) return off[0];
        if (lt == 3'd3 || lt == 3'd4) return 1'b0;
        return off != 2'd0;
    endfunction

    task automatic sync();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [4:0] r, input logic [31:0] d, input logic m);
        exp_t e;
        e.r = r;
        e.d = d;
        e.m = m;
        exp_q.push_back(e);
    endtask

    // Present one instruction and return #1 after the edge that accepts it.
    task automatic send(input logic mtr, input logic rw, input logic [2:0] lt,
                        input logic [4:0] rd, input logic [31:0] alu);
        int n = 0;
        while (!in_ready && n < 20) begin
            sync();
            n++;
        end
        if (n >= 20) begin
            checks++;
            errors++;
            $display("FAIL ready_timeout got in_ready=0 for 20 cycles expected 1");
        end
        in_valid     = 1'b1;
        in_memToReg  = mtr;
        in_regWrite  = rw;
        in_loadType  = lt;
        in_writeReg  = rd;
        in_aluResult = alu;
        sync();
        in_valid = 1'b0;
    endtask

    task automatic check_bit(input string name, input logic got, input logic want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got %b expected %b", name, got, want);
        end
    endtask

    // Load with response 'lat' cycles after acceptance; checks stall and WB timing.
    task automatic do_load(input logic [2:0] lt, input logic [1:0] off, input logic [31:0] rdata,
                           input int lat, input logic [4:0] rd, input logic [31:0] expd, input logic expm);
        sync();
        push(rd, expd, expm);
        send(1'b1, 1'b1, lt, rd, {30'h0400_0000, off});
        for (int i = 0; i < lat - 1; i++) begin
            @(negedge clk);
            check_bit("load_stall_ready", in_ready, 1'b0);
            sync();
        end
        mem_rdataValid = 1'b1;
        mem_rdata      = rdata;
        @(negedge clk);
        check_bit("load_resp_ready", in_ready, 1'b0);
        sync();
        mem_rdataValid = 1'b0;
        mem_rdata      = 32'h0;
        @(negedge clk);
        check_bit("load_wb_timing", WB, 1'b1);
        check_bit("load_write_ready", in_ready, 1'b1);
    endtask

    task automatic test_reset();
        @(negedge clk);
        check_bit("reset_ready", in_ready, 1'b0);
        check_bit("reset_wb", WB, 1'b0);
        checks++;
        if ({writeReg, writeData, misalign} !== 38'h0) begin
            errors++;
            $display("FAIL reset_outputs got reg=%0d data=%h mis=%b expected 0", writeReg, writeData, misalign);
        end
        sync();
        rst = 1'b0;
        @(negedge clk);
        check_bit("post_reset_ready", in_ready, 1'b1);
    endtask

    task automatic test_alu_write();
        sync();
        push(5'd20, 32'd50, 1'b0);
        send(1'b0, 1'b1, 3'd0, 5'd20, 32'd50);
        @(negedge clk);
        check_bit("alu_wb_n1", WB, 1'b1);
        sync();
        @(negedge clk);
        check_bit("alu_wb_n2", WB, 1'b0);
    endtask

    task automatic test_load_extend();
        do_load(3'd3, 2'd0, 32'h80F17F01, 1, 5'd1, 32'hFFFFFF80, 1'b0);
        do_load(3'd4, 2'd1, 32'h80F17F01, 2, 5'd2, 32'h000000F1, 1'b0);
        do_load(3'd1, 2'd2, 32'h80F17F01, 1, 5'd3, 32'h00007F01, 1'b0);
        do_load(3'd2, 2'd0, 32'h80F17F01, 1, 5'd4, 32'h000080F1, 1'b0);
        for (int i = 0; i < 8; i++) begin
            logic [2:0]  lt;
            logic [1:0]  off;
            logic [31:0] w;
            lt  = 3'($urandom_range(7, 0));
            off = 2'($urandom_range(3, 0));
            w   = $urandom;
            do_load(lt, off, w, int'($urandom_range(3, 1)), 5'(i + 8), model_ext(lt, off, w), model_mis(lt, off));
        end
    endtask

    task automatic test_mem_wait();
        do_load(3'd0, 2'd0, 32'h1234_5678, 3, 5'd6, 32'h1234_5678, 1'b0);
    endtask

    task automatic test_flush();
        sync();
        send(1'b1, 1'b1, 3'd0, 5'd5, 32'h0);
        flush = 1'b1;
        @(negedge clk);
        check_bit("flush_wait_ready", in_ready, 1'b0);
        sync();
        flush = 1'b0;
        @(negedge clk);
        check_bit("drain_ready", in_ready, 1'b0);
        sync();
        mem_rdataValid = 1'b1;
        @(negedge clk);
        check_bit("drain_resp_ready", in_ready, 1'b0);
        sync();
        mem_rdataValid = 1'b0;
        @(negedge clk);
        check_bit("drain_done_ready", in_ready, 1'b1);
        check_bit("drain_no_wb", WB, 1'b0);
        // flush coincident with the response goes straight to IDLE
        sync();
        send(1'b1, 1'b1, 3'd0, 5'd5, 32'h0);
        flush          = 1'b1;
        mem_rdataValid = 1'b1;
        sync();
        flush          = 1'b0;
        mem_rdataValid = 1'b0;
        @(negedge clk);
        check_bit("flush_resp_ready", in_ready, 1'b1);
        check_bit("flush_resp_no_wb", WB, 1'b0);
        // flush in IDLE blocks acceptance
        sync();
        in_valid = 1'b1; in_memToReg = 1'b0; in_regWrite = 1'b1; in_writeReg = 5'd7; in_aluResult = 32'h77;
        flush = 1'b1;
        sync();
        in_valid = 1'b0;
        flush    = 1'b0;
        @(negedge clk);
        check_bit("idle_flush_no_wb", WB, 1'b0);
        // flush in WRITE suppresses the write
        sync();
        send(1'b0, 1'b1, 3'd0, 5'd9, 32'h99);
        flush = 1'b1;
        @(negedge clk);
        check_bit("write_flush_no_wb", WB, 1'b0);
        sync();
        flush = 1'b0;
        push(5'd11, 32'hCAFE_0011, 1'b0);
        send(1'b0, 1'b1, 3'd0, 5'd11, 32'hCAFE_0011);
        @(negedge clk);
        check_bit("after_flush_wb", WB, 1'b1);
    endtask

    task automatic test_reg0_misalign();
        sync();
        send(1'b0, 1'b1, 3'd0, 5'd0, 32'h1111);
        @(negedge clk);
        check_bit("reg0_no_wb", WB, 1'b0);
        check_bit("reg0_ready", in_ready, 1'b1);
        do_load(3'd0, 2'd2, 32'hDEADBEEF, 1, 5'd12, 32'hDEADBEEF, 1'b1);
        check_bit("lw_misalign_pulse", misalign, 1'b1);
        do_load(3'd1, 2'd1, 32'h80F17F01, 2, 5'd13, 32'hFFFF80F1, 1'b1);
        sync();
        @(negedge clk);
        check_bit("misalign_one_cycle", misalign, 1'b0);
    endtask

    task automatic test_back_to_back();
        sync();
        for (int i = 0; i < 4; i++) begin
            push(5'(i + 21), 32'h100 + 32'(i), 1'b0);
            in_valid = 1'b1; in_memToReg = 1'b0; in_regWrite = 1'b1;
            in_writeReg = 5'(i + 21); in_aluResult = 32'h100 + 32'(i);
            sync();
            @(negedge clk);
            check_bit("b2b_wb", WB, 1'b1);
            check_bit("b2b_ready", in_ready, 1'b1);
        end
        in_valid = 1'b0;
        sync();
        @(negedge clk);
        check_bit("b2b_end_wb", WB, 1'b0);
    endtask

    task automatic test_reset_mid();
        sync();
        send(1'b1, 1'b1, 3'd0, 5'd14, 32'h0);
        rst = 1'b1;
        @(negedge clk);
        check_bit("rst_mid_ready", in_ready, 1'b0);
        sync();
        rst = 1'b0;
        @(negedge clk);
        check_bit("rst_mid_wb", WB, 1'b0);
        checks++;
        if (writeData !== 32'h0) begin
            errors++;
            $display("FAIL rst_mid_data got %h expected 00000000", writeData);
        end
        check_bit("rst_mid_ready_after", in_ready, 1'b1);
        push(5'd15, 32'h5555_AAAA, 1'b0);
        sync();
        send(1'b0, 1'b1, 3'd0, 5'd15, 32'h5555_AAAA);
        @(negedge clk);
        check_bit("rst_mid_alu_wb", WB, 1'b1);
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_regWrite = 1'b0; in_memToReg = 1'b0;
        in_loadType = 3'd0; in_writeReg = 5'd0; in_aluResult = 32'h0;
        mem_rdata = 32'h0; mem_rdataValid = 1'b0; flush = 1'b0;
        test_reset();
        test_alu_write();
        test_load_extend();
        test_mem_wait();
        test_flush();
        test_reg0_misalign();
        test_back_to_back();
        test_reset_mid();
        repeat (3) sync();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL missing_writes got %0d pending expected 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
